cp_ring_scheduler: RTL
======================

# cp_ring_scheduler

Synchronous token scheduler for the 8-stage self-timed C-element control ring that produces the per-stage latch strobes CP1..CP8. It tracks ring occupancy and admits external tokens. It advances tokens stage to stage under per-stage holds, drains or recirculates tokens at the last stage, and emits one-cycle CP strobes. It serves as the clocked sequencer and reference model for the handshake ring in the DDP datapath.

## Interface
Parameters:
- STAGES, 8, number of ring stages (legal 2..16)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- MR  in  1  master reset; synchronous, active-high
- Send_in  in  1  token injection request, held until Ack_out
- Ack_out  out  1  one-cycle pulse: injection accepted
- Hold  in  STAGES  per-stage stall; Hold[i]=1 freezes the token in stage i
- Drain_in  in  1  when 1, a token leaving the last stage exits the ring instead of wrapping
- Send_out  out  1  one-cycle pulse: token drained from the last stage
- CP  out  STAGES  one-cycle latch strobe; CP[i]=1 when a token is written into stage i
- Occ  out  STAGES  registered occupancy vector
- Count  out  $clog2(STAGES+1)  number of tokens in the ring

## Operation
- State is Occ, a bit per stage: 1 = token, 0 = bubble. All firing decisions use the current registered Occ only.
- Forward move, stage i to i+1 (i < STAGES-1): fires iff Occ[i] & ~Hold[i] & ~Occ[i+1]. A token never moves into a stage that is occupied this cycle, even if that stage is itself firing.
- Last stage, i = STAGES-1, when Occ[i] & ~Hold[i]:
  - Drain_in=1: the token exits and Send_out pulses. This does not depend on Occ[0].
  - Drain_in=0: the token wraps into stage 0 iff ~Occ[0]. Otherwise it stays.
- Injection into stage 0: candidate iff Send_in & ~Occ[0] & ~Ack_out & (Count < STAGES-1). This guarantees at least one bubble, so the ring can never deadlock full.
- Wrap and injection both target stage 0 in the same cycle: the wrap wins and the injection waits (default priority).
- Next-state Occ[i]: cleared when stage i's token leaves; set when a token enters. A stage can empty and fill in the same cycle. Stage 0 can lose its token forward while neither wrap nor injection is eligible, because both require ~Occ[0].
- Count next = Count + inject − drain. Count never exceeds STAGES-1 through injection.
- Hold on a stage blocks both its exit and its upstream neighbour, because that neighbour's target stays occupied.
- Requester protocol: keep Send_in high until Ack_out is seen. The cycle in which Ack_out=1 never accepts a second token. Send_in still high after that cycle is a new request.

## Timing
- Reset (MR=1 at an edge): Occ=0, Count=0, CP=0, Ack_out=0, Send_out=0 on the next cycle. In-flight tokens are discarded without Send_out. A pending Send_in is not acknowledged.
- MR overrides all other inputs in the same cycle.
- All outputs are registered. An event decided in cycle t appears in cycle t+1.
- Injection accepted at edge t: Occ[0], CP[0] and Ack_out are all 1 in cycle t+1.
- Unstalled token with empty downstream stages: advances exactly one stage per cycle. CP[i+1] follows CP[i] by 1 cycle.
- Drain at edge t: Send_out=1 and Occ[STAGES-1]=0 in t+1. CP does not pulse for a drain.
- Two tokens in adjacent stages: the follower moves one cycle after the leader vacates, so dense traffic has a spacing of at least 2 stages.

## Configuration
- CP_INJECT_PRIO_EN
  - Defined: injection beats wrap on a stage-0 conflict. The wrapping token stays in stage STAGES-1 that cycle. The bubble guard (Count < STAGES-1) still applies.
  - Undefined: wrap wins (default priority above).

## Test plan
- Reset then Send_in=1, Hold=0, Drain_in=0: Ack_out and CP[0] in cycle 1. CP[1]..CP[7] follow in cycles 2..8. CP[0] pulses again in cycle 9 (wrap). Count=1 throughout.
- Send_in held high continuously with no holds: tokens admitted until Count=7, then Ack_out stays 0. Occ never reaches 8'hFF.
- Single token, Hold[3]=1 for 5 cycles: token parks in stage 3 with Occ=8'h08. No CP pulses during the hold. It resumes one stage per cycle after release.
- Drain_in=1 with token in stage 7: Send_out=1 next cycle, Count drops by 1, no CP[0].
- Token in stage 7, Occ[0]=0, Send_in=1 in the same cycle: default build wraps (CP[0], no Ack_out). With CP_INJECT_PRIO_EN, Ack_out=1 and the token stays in stage 7.
- MR asserted with Count=5: next cycle Occ=0, Count=0, no Send_out and no Ack_out.

Source files
------------

// File: rtl/cp_ring_scheduler_if.sv
// Handshake/bus bundle for the CP ring scheduler.
// Requester drives the master side; the scheduler is the slave.
interface cp_ring_scheduler_if #(
    parameter int STAGES = 8
);
    localparam int CW = $clog2(STAGES + 1);

    logic              Send_in;
    logic              Ack_out;
    logic [STAGES-1:0] Hold;
    logic              Drain_in;
    logic              Send_out;
    logic [STAGES-1:0] CP;
    logic [STAGES-1:0] Occ;
    logic [CW-1:0]     Count;

    modport master (
        output Send_in, Hold, Drain_in,
        input  Ack_out, Send_out, CP, Occ, Count
    );

    modport slave (
        input  Send_in, Hold, Drain_in,
        output Ack_out, Send_out, CP, Occ, Count
    );
endinterface

// File: rtl/cp_ring_scheduler.sv
// Clocked token scheduler for the 8-stage C-element CP strobe ring.
// Optional CP_INJECT_PRIO_EN: injection beats wrap on a stage-0 conflict.
module cp_ring_scheduler #(
    parameter int STAGES = 8
) (
    input logic              CLK,
    input logic              MR,
    cp_ring_scheduler_if.slave bus
);
    localparam int CW = $clog2(STAGES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(STAGES - 1);

    logic [STAGES-1:0] occ_q;
    logic [STAGES-1:0] cp_q;
    logic [STAGES-1:0] occ_d;
    logic [STAGES-1:0] enter;
    logic [STAGES-1:0] leave;
    logic [STAGES-2:0] move;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              ack_q;
    logic              so_q;
    logic              last_go;
    logic              drain;
    logic              wrap_cand;
    logic              inj_cand;
    logic              wrap;
    logic              inject;

    always_comb begin
        move = '0;
        for (int i = 0; i < STAGES - 1; i++) begin
            move[i] = occ_q[i] & ~bus.Hold[i] & ~occ_q[i+1];
        end

        last_go   = occ_q[STAGES-1] & ~bus.Hold[STAGES-1];
        drain     = last_go & bus.Drain_in;
        wrap_cand = last_go & ~bus.Drain_in & ~occ_q[0];
        // Count guard keeps one bubble so the ring can never lock up full
        inj_cand  = bus.Send_in & ~occ_q[0] & ~ack_q & (cnt_q < MAX_CNT);

`ifdef CP_INJECT_PRIO_EN
        inject = inj_cand;
        wrap   = wrap_cand & ~inj_cand;
`else
        wrap   = wrap_cand;
        inject = inj_cand & ~wrap_cand;
`endif

        enter = {move, wrap | inject};
        leave = {drain | wrap, move};
        occ_d = (occ_q & ~leave) | enter;
        cnt_d = cnt_q + CW'(inject) - CW'(drain);
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            occ_q <= '0;
            cp_q  <= '0;
            cnt_q <= '0;
            ack_q <= 1'b0;
            so_q  <= 1'b0;
        end else begin
            occ_q <= occ_d;
            cp_q  <= enter;
            cnt_q <= cnt_d;
            ack_q <= inject;
            so_q  <= drain;
        end
    end

    assign bus.Occ      = occ_q;
    assign bus.CP       = cp_q;
    assign bus.Count    = cnt_q;
    assign bus.Ack_out  = ack_q;
    assign bus.Send_out = so_q;
endmodule
